// File: rtl/mul_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg -- shared definitions for the multiply/divide unit.
//   MDU_SIZE    : default operand/result width
//   mdu_op_e    : operation encodings (MULT, MULTU, DIV, DIVU)
//   mdu_state_e : sequencer states (IDLE -> RUN -> FIX -> DONE)
//   isSignedOp / isMulOp : small decode helpers used by the top and sign fix
// ---------------------------------------------------------------------------
package mdu_pkg;

  localparam int MDU_SIZE = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_e;

  function automatic logic isSignedOp(mdu_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic isMulOp(mdu_op_e op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// ---------------------------------------------------------------------------
// mul_div_unit_if -- request/result bundle of the multiply/divide unit.
//   Start, Op, SrcA, SrcB : request side (driven by the master)
//   Busy, Done, HLEN      : status; HLEN is the hi/lo register write enable
//   HiOut, LoOut          : results toward the hi/lo registers
// ---------------------------------------------------------------------------
interface mul_div_unit_if
  import mdu_pkg::*;
#(
  parameter int SIZE = MDU_SIZE
);

  logic            Start;
  mdu_op_e         Op;
  logic [SIZE-1:0] SrcA;
  logic [SIZE-1:0] SrcB;
  logic            Busy;
  logic            Done;
  logic            HLEN;
  logic [SIZE-1:0] HiOut;
  logic [SIZE-1:0] LoOut;

  modport master (
    output Start, Op, SrcA, SrcB,
    input  Busy, Done, HLEN, HiOut, LoOut
  );

  modport slave (
    input  Start, Op, SrcA, SrcB,
    output Busy, Done, HLEN, HiOut, LoOut
  );

endinterface

// File: rtl/mul_div_unit_sign_fix.sv
// ---------------------------------------------------------------------------
// mdu_sign_fix -- sign handling around the unsigned iterative datapath.
//   Entry side (used at accept): op_i, srcA_i, srcB_i -> operand magnitudes
//     aMag_o/bMag_o and the negate flags negHi_o/negLo_o to be latched.
//   Exit side (used in FIX): latched isMul_i/negHi_i/negLo_i and the raw
//     unsigned result hi_i/lo_i -> corrected hiFix_o/loFix_o.
// ---------------------------------------------------------------------------
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int SIZE = MDU_SIZE
) (
  input  mdu_op_e         op_i,
  input  logic [SIZE-1:0] srcA_i,
  input  logic [SIZE-1:0] srcB_i,
  output logic [SIZE-1:0] aMag_o,
  output logic [SIZE-1:0] bMag_o,
  output logic            negHi_o,
  output logic            negLo_o,
  input  logic            isMul_i,
  input  logic            negHi_i,
  input  logic            negLo_i,
  input  logic [SIZE-1:0] hi_i,
  input  logic [SIZE-1:0] lo_i,
  output logic [SIZE-1:0] hiFix_o,
  output logic [SIZE-1:0] loFix_o
);

  logic signA;
  logic signB;

  // Magnitudes and result signs. The quotient is not negated for a zero
  // divisor so the all-ones quotient survives; the remainder (which then
  // equals |SrcA|) takes the dividend sign and so reproduces SrcA.
  always_comb begin
    signA  = isSignedOp(op_i) & srcA_i[SIZE-1];
    signB  = isSignedOp(op_i) & srcB_i[SIZE-1];
    aMag_o = signA ? -srcA_i : srcA_i;
    bMag_o = signB ? -srcB_i : srcB_i;
    if (isMulOp(op_i)) begin
      negHi_o = signA ^ signB;
      negLo_o = signA ^ signB;
    end else begin
      negHi_o = signA;
      negLo_o = (signA ^ signB) & (|srcB_i);
    end
  end

  // A product is negated as one 2*SIZE-bit value; quotient and remainder
  // are negated independently.
  always_comb begin
    hiFix_o = hi_i;
    loFix_o = lo_i;
    if (isMul_i) begin
      if (negLo_i) begin
        {hiFix_o, loFix_o} = -{hi_i, lo_i};
      end
    end else begin
      if (negHi_i) begin
        hiFix_o = -hi_i;
      end
      if (negLo_i) begin
        loFix_o = -lo_i;
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit -- iterative multiply/divide unit feeding the hi/lo registers.
//   CLK : clock, rising edge
//   RST : asynchronous reset, active low
//   bus : mul_div_unit_if.slave (Start/Op/SrcA/SrcB in; Busy/Done/HLEN/
//         HiOut/LoOut out)
// One request runs IDLE -> RUN (SIZE cycles) -> FIX -> DONE; Done/HLEN pulse
// in the DONE cycle, the (SIZE+2)th cycle after the accept edge.
// ---------------------------------------------------------------------------
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int SIZE = MDU_SIZE
) (
  input logic             CLK,
  input logic             RST,
  mul_div_unit_if.slave   bus
);

  localparam int CW = $clog2(SIZE);

  mdu_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [SIZE-1:0] hi_q;
  logic [SIZE-1:0] lo_q;
  logic [SIZE-1:0] bMag_q;
  logic [SIZE-1:0] hiOut_q;
  logic [SIZE-1:0] loOut_q;
  logic            isMul_q;
  logic            negHi_q;
  logic            negLo_q;
  logic            busy_q;
  logic            done_q;

  logic [SIZE-1:0] aMag;
  logic [SIZE-1:0] bMag;
  logic            negHi;
  logic            negLo;
  logic [SIZE-1:0] hiFix;
  logic [SIZE-1:0] loFix;
  logic [SIZE-1:0] shifted;
  logic [SIZE-1:0] addA;
  logic [SIZE-1:0] addB;
  logic [SIZE:0]   sum;
  logic            divOk;
  logic [SIZE-1:0] hi_d;
  logic [SIZE-1:0] lo_d;

  mdu_sign_fix #(.SIZE(SIZE)) u_sign_fix (
    .op_i    (bus.Op),
    .srcA_i  (bus.SrcA),
    .srcB_i  (bus.SrcB),
    .aMag_o  (aMag),
    .bMag_o  (bMag),
    .negHi_o (negHi),
    .negLo_o (negLo),
    .isMul_i (isMul_q),
    .negHi_i (negHi_q),
    .negLo_i (negLo_q),
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .hiFix_o (hiFix),
    .loFix_o (loFix)
  );

  // One SIZE-bit adder serves both operations. Multiply adds the
  // multiplicand into hi and shifts {carry,hi,lo} right. Divide shifts
  // {hi,lo} left and subtracts the divisor (add ~d + 1); the bit shifted
  // out of hi is an implicit 33rd bit, so a set bit there means the
  // subtraction always fits even when the carry is clear.
  always_comb begin
    shifted = {hi_q[SIZE-2:0], lo_q[SIZE-1]};
    addA    = isMul_q ? hi_q : shifted;
    addB    = isMul_q ? bMag_q : ~bMag_q;
    sum     = {1'b0, addA} + {1'b0, addB} + {{SIZE{1'b0}}, ~isMul_q};
    divOk   = hi_q[SIZE-1] | sum[SIZE];
    if (isMul_q) begin
      if (lo_q[0]) begin
        hi_d = sum[SIZE:1];
        lo_d = {sum[0], lo_q[SIZE-1:1]};
      end else begin
        hi_d = {1'b0, hi_q[SIZE-1:1]};
        lo_d = {hi_q[0], lo_q[SIZE-1:1]};
      end
    end else begin
      hi_d = divOk ? sum[SIZE-1:0] : shifted;
      lo_d = {lo_q[SIZE-2:0], divOk};
    end
  end

  // Sequencer. Start is only looked at in IDLE, so requests during a run
  // (DONE cycle included) are dropped. Results update only on the FIX edge
  // and otherwise hold.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      bMag_q  <= '0;
      hiOut_q <= '0;
      loOut_q <= '0;
      isMul_q <= 1'b0;
      negHi_q <= 1'b0;
      negLo_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Start) begin
            state_q <= RUN;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= aMag;
            bMag_q  <= bMag;
            isMul_q <= isMulOp(bus.Op);
            negHi_q <= negHi;
            negLo_q <= negLo;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(SIZE - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hiOut_q <= hiFix;
          loOut_q <= loFix;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;
  assign bus.HLEN  = done_q;
  assign bus.HiOut = hiOut_q;
  assign bus.LoOut = loOut_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit -- self-checking bench for mul_div_unit (SIZE = 32).
// Expected {hi,lo} results are queued when a request is driven and popped
// when Done is seen. Cycle numbering: the first negedge after the accept
// edge is cycle 1, so Done is expected in cycle 34.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  int         lat;
  logic       got;
  logic       obsHlen;
  logic       obsBusy;
  logic [W-1:0] obsHi;
  logic [W-1:0] obsLo;
  exp_t       exp;

  mul_div_unit_if #(.SIZE(W)) bus ();

  mul_div_unit #(.SIZE(W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference results straight from SV arithmetic plus the two special cases
  function automatic exp_t model(mdu_op_e op, logic [W-1:0] a, logic [W-1:0] b);
    exp_t r;
    logic signed [2*W-1:0] p;
    logic signed [W-1:0] da;
    logic signed [W-1:0] db;
    da = a;
    db = b;
    case (op)
      OP_MULTU: r = {32'b0, a} * {32'b0, b};
      OP_MULT: begin
        p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        r = p;
      end
      OP_DIVU: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
        else r = {32'(da % db), 32'(da / db)};
      end
    endcase
    return r;
  endfunction

  // Drive one request for one cycle; returns at cycle 1 after the accept edge
  task automatic applyStimulus(input mdu_op_e op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input exp_t e);
    @(negedge clk);
    bus.Op    = op;
    bus.SrcA  = a;
    bus.SrcB  = b;
    bus.Start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  // Wait (bounded) for Done starting at cycle startC; capture outputs and pop
  task automatic waitDone(input int startC);
    got = 1'b0;
    lat = 0;
    for (int c = startC; c <= startC + 60; c++) begin
      if (bus.Done === 1'b1) begin
        got = 1'b1;
        lat = c;
        obsHi = bus.HiOut;
        obsLo = bus.LoOut;
        obsHlen = bus.HLEN;
        obsBusy = bus.Busy;
        break;
      end
      @(negedge clk);
    end
    if (sb.size() > 0) exp = sb.pop_front();
    else exp = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.Start = 1'b0;
    bus.Op = OP_MULT;
    bus.SrcA = '0;
    bus.SrcB = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.Busy, bus.Done, bus.HLEN} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_status: got %b want 000", {bus.Busy, bus.Done, bus.HLEN});
    end
    total++;
    if ({bus.HiOut, bus.LoOut} !== 64'h0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %h_%h want 0_0", bus.HiOut, bus.LoOut);
    end
    rst = 1'b1;
  endtask

  task automatic test_multu();
    applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001});
    total++;
    if (bus.Busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL multu_busy_start: got %b want 1", bus.Busy);
    end
    waitDone(1);
    total++;
    if (!got || lat != 34) begin
      bad++;
      $display("[TB] FAIL multu_latency: got %0d (seen=%b) want 34", lat, got);
    end
    total++;
    if (obsHlen !== 1'b1 || obsBusy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL multu_hlen_busy: got hlen=%b busy=%b want 1 1", obsHlen, obsBusy);
    end
    total++;
    if ({obsHi, obsLo} !== {exp.hi, exp.lo}) begin
      bad++;
      $display("[TB] FAIL multu_result: got %h_%h want %h_%h", obsHi, obsLo, exp.hi, exp.lo);
    end
    @(negedge clk);
    total++;
    if ({bus.Busy, bus.Done, bus.HLEN} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL multu_pulse_end: got %b want 000", {bus.Busy, bus.Done, bus.HLEN});
    end
    total++;
    if ({bus.HiOut, bus.LoOut} !== {exp.hi, exp.lo}) begin
      bad++;
      $display("[TB] FAIL multu_hold: got %h_%h want %h_%h", bus.HiOut, bus.LoOut, exp.hi, exp.lo);
    end
  endtask

  task automatic test_mult();
    applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'd5, {32'hFFFFFFFF, 32'hFFFFFFF1});
    waitDone(1);
    total++;
    if (!got || lat != 34 || {obsHi, obsLo} !== {exp.hi, exp.lo}) begin
      bad++;
      $display("[TB] FAIL mult_neg3x5: got %h_%h lat=%0d want %h_%h lat=34",
               obsHi, obsLo, lat, exp.hi, exp.lo);
    end
  endtask

  task automatic test_div();
    mdu_op_e      ops[4];
    logic [W-1:0] as[4];
    logic [W-1:0] bs[4];
    exp_t         es[4];
    ops[0] = OP_DIV;  as[0] = 32'hFFFFFFF9; bs[0] = 32'd2;        es[0] = {32'hFFFFFFFF, 32'hFFFFFFFD};
    ops[1] = OP_DIVU; as[1] = 32'd100;      bs[1] = 32'd0;        es[1] = {32'h00000064, 32'hFFFFFFFF};
    ops[2] = OP_DIV;  as[2] = 32'h80000000; bs[2] = 32'hFFFFFFFF; es[2] = {32'h00000000, 32'h80000000};
    ops[3] = OP_DIV;  as[3] = 32'hFFFFFFF7; bs[3] = 32'd0;        es[3] = {32'hFFFFFFF7, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ops[i], as[i], bs[i], es[i]);
      waitDone(1);
      total++;
      if (!got || {obsHi, obsLo} !== {exp.hi, exp.lo}) begin
        bad++;
        $display("[TB] FAIL div_case%0d: got %h_%h want %h_%h", i, obsHi, obsLo, exp.hi, exp.lo);
      end
    end
  endtask

  task automatic test_random();
    mdu_op_e      op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 8; i++) begin
      op = mdu_op_e'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      if (($urandom_range(0, 1) == 1) && (op == OP_DIV)) b = -b;
      applyStimulus(op, a, b, model(op, a, b));
      waitDone(1);
      total++;
      if (!got || {obsHi, obsLo} !== {exp.hi, exp.lo}) begin
        bad++;
        $display("[TB] FAIL random%0d op=%0d a=%h b=%h: got %h_%h want %h_%h",
                 i, op, a, b, obsHi, obsLo, exp.hi, exp.lo);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic seenDone;
    applyStimulus(OP_MULTU, 32'd1234, 32'd5678, model(OP_MULTU, 32'd1234, 32'd5678));
    repeat (4) @(negedge clk);
    bus.Op = OP_DIVU;
    bus.SrcA = 32'hDEADBEEF;
    bus.SrcB = 32'd3;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    waitDone(6);
    total++;
    if (!got || lat != 34 || {obsHi, obsLo} !== {exp.hi, exp.lo}) begin
      bad++;
      $display("[TB] FAIL ignore_midrun: got %h_%h lat=%0d want %h_%h lat=34",
               obsHi, obsLo, lat, exp.hi, exp.lo);
    end
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    total++;
    if (bus.Busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ignore_in_done: got busy=%b want 0", bus.Busy);
    end
    seenDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Done !== 1'b0) seenDone = 1'b1;
    end
    total++;
    if (seenDone !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ignore_no_extra_done: got %b want 0", seenDone);
    end
  endtask

  task automatic test_back_to_back();
    exp_t first;
    applyStimulus(OP_DIVU, 32'd1000, 32'd7, {32'd6, 32'd142});
    waitDone(1);
    first = exp;
    total++;
    if (!got || {obsHi, obsLo} !== {exp.hi, exp.lo}) begin
      bad++;
      $display("[TB] FAIL b2b_first: got %h_%h want %h_%h", obsHi, obsLo, exp.hi, exp.lo);
    end
    applyStimulus(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'h0, 32'h1});
    total++;
    if (bus.Busy !== 1'b1 || {bus.HiOut, bus.LoOut} !== {first.hi, first.lo}) begin
      bad++;
      $display("[TB] FAIL b2b_accept_hold: got busy=%b %h_%h want 1 %h_%h",
               bus.Busy, bus.HiOut, bus.LoOut, first.hi, first.lo);
    end
    waitDone(1);
    total++;
    if (!got || lat != 34 || {obsHi, obsLo} !== {exp.hi, exp.lo}) begin
      bad++;
      $display("[TB] FAIL b2b_second: got %h_%h lat=%0d want %h_%h lat=34",
               obsHi, obsLo, lat, exp.hi, exp.lo);
    end
  endtask

  task automatic test_reset_abort();
    logic seenDone;
    exp_t dropped;
    applyStimulus(OP_MULTU, 32'd77, 32'd99, model(OP_MULTU, 32'd77, 32'd99));
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    dropped = sb.pop_front();
    total++;
    if ({bus.Busy, bus.Done, bus.HLEN} !== 3'b000 || {bus.HiOut, bus.LoOut} !== 64'h0) begin
      bad++;
      $display("[TB] FAIL abort_outputs: got %b %h_%h want 000 0_0 (dropped %h)",
               {bus.Busy, bus.Done, bus.HLEN}, bus.HiOut, bus.LoOut, dropped);
    end
    seenDone = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.Done !== 1'b0 || bus.HLEN !== 1'b0) seenDone = 1'b1;
    end
    rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.Done !== 1'b0 || bus.HLEN !== 1'b0) seenDone = 1'b1;
    end
    total++;
    if (seenDone !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_no_done: got %b want 0", seenDone);
    end
    applyStimulus(OP_DIV, 32'd100, 32'hFFFFFFF9, {32'd2, 32'hFFFFFFF2});
    waitDone(1);
    total++;
    if (!got || lat != 34 || {obsHi, obsLo} !== {exp.hi, exp.lo}) begin
      bad++;
      $display("[TB] FAIL abort_restart: got %h_%h lat=%0d want %h_%h lat=34",
               obsHi, obsLo, lat, exp.hi, exp.lo);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter SIZE, default 32: operand and result width.
REQ-002 The block SHALL have port CLK, input, 1: clock, rising-edge active.
REQ-003 The block SHALL have port RST, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port Start, input, 1: operation request, sampled only in IDLE.
REQ-005 The block SHALL have port Op, input, 2: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have ports SrcA and SrcB, input, SIZE each: multiplicand/dividend and multiplier/divisor.
REQ-007 The block SHALL have port Busy, output, 1: high from the accept edge until the Done cycle, inclusive.
REQ-008 The block SHALL have port Done, output, 1: single-cycle completion pulse.
REQ-009 The block SHALL have port HLEN, output, 1: hi/lo register write enable, identical to Done.
REQ-010 The block SHALL have ports HiOut and LoOut, output, SIZE each: results, driven to the hi/lo register data inputs.

Function
REQ-011 The block SHALL implement the state machine IDLE -> RUN -> FIX -> DONE -> IDLE.
REQ-012 Start=1 in IDLE SHALL latch Op, SrcA and SrcB, set the iteration counter to 0, and enter RUN on the same edge.
REQ-013 RUN SHALL perform exactly SIZE iterations, one per cycle, then enter FIX.
REQ-014 Multiply iterations SHALL use shift-add on operand magnitudes.
REQ-015 Divide iterations SHALL use restoring shift-subtract on operand magnitudes.
REQ-016 FIX SHALL apply sign correction in one cycle, then enter DONE.
REQ-017 DONE SHALL assert Done and HLEN for exactly one cycle, with HiOut/LoOut valid in that cycle, then return to IDLE.
REQ-018 Done SHALL rise SIZE+2 cycles after the accept edge, i.e. 34 cycles at SIZE=32.
REQ-019 Start SHALL be ignored while Busy=1, including in the DONE cycle; there SHALL be no queueing.
REQ-020 A new Start SHALL be accepted in the first IDLE cycle after DONE.
REQ-021 Operands SHALL be captured at the accept edge; SrcA/SrcB changes during RUN SHALL have no effect.
REQ-022 MULT/MULTU SHALL produce a full 2*SIZE-bit product, with HiOut = upper half and LoOut = lower half.
REQ-023 For MULT, operands SHALL be two's complement, and the product SHALL be negated when operand signs differ.
REQ-024 DIV/DIVU SHALL produce LoOut = quotient and HiOut = remainder.
REQ-025 For DIV, the quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-026 For divide by zero (both DIV and DIVU), the result SHALL be LoOut = all ones and HiOut = SrcA.
REQ-027 DIV with SrcA = most-negative value and SrcB = -1 SHALL give LoOut = most-negative value and HiOut = 0.
REQ-028 HiOut and LoOut SHALL hold their values after DONE until the next DONE.

Reset
REQ-029 When RST=0, the state SHALL go to IDLE, the counter and datapath registers SHALL clear, and Busy, Done, HLEN, HiOut and LoOut SHALL be 0.
REQ-030 Reset during RUN or FIX SHALL abort the operation with no Done/HLEN pulse.
REQ-031 After reset release, the first Start SHALL be accepted normally.

Structure
REQ-032 A shared package mdu_pkg SHALL hold the Op encodings, the state enumeration and the default SIZE.
REQ-033 The datapath SHALL be a single SIZE-bit adder/subtractor shared between multiply and divide; no hardware multiplier or divider SHALL be inferred.
REQ-034 The sign-correction logic (magnitude before RUN, negation in FIX) SHALL be a sub-module named mdu_sign_fix.

Verification
REQ-035 The bench SHALL drive MULTU 0xFFFFFFFF x 0xFFFFFFFF and check HiOut=0xFFFFFFFE, LoOut=0x00000001, with Done and HLEN high for one cycle exactly 34 cycles after accept.
REQ-036 The bench SHALL drive MULT -3 x 5 and check HiOut=0xFFFFFFFF, LoOut=0xFFFFFFF1.
REQ-037 The bench SHALL drive DIV -7 / 2 and check LoOut=0xFFFFFFFD, HiOut=0xFFFFFFFF; DIVU 100 / 0 and check LoOut=0xFFFFFFFF, HiOut=0x00000064.
REQ-038 The bench SHALL drive DIV 0x80000000 / 0xFFFFFFFF and check LoOut=0x80000000, HiOut=0x00000000.
REQ-039 The bench SHALL pulse Start with new operands 5 cycles after an accept and check that it is ignored and the original result is returned.
REQ-040 The bench SHALL assert RST=0 at cycle 10 of a RUN and check that Busy falls immediately, no Done occurs, and outputs are 0; the next Start SHALL complete correctly.
